tt_divider_seq: RTL

TT_DIVIDER_SEQ -- requirements
Module: tt_divider_seq

---
 rtl/tt_divider_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tt_divider_seq.sv
// Sequential 16-by-8 unsigned restoring divider: one quotient bit per clock, MSB first.
// Results are registered and only change on the cycle done pulses.
module tt_divider_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        ready,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start, ready=1
    // RUN   | 16 restoring steps, one per clock
    // FIN   | load results, pulse done, back to IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dsr_q, dsr_d;
    logic [8:0]  prem_q, prem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] quot_q, quot_d;
    logic [7:0]  rem_q, rem_d;
    logic        dbz_q, dbz_d;
    logic        done_q, done_d;

    // One extra bit above the 9-bit shifted remainder turns the trial
    // subtraction's borrow into a sign bit.
    logic [9:0]  shifted;
    logic [9:0]  trial;
    logic        no_borrow;

    always_comb begin
        shifted   = {prem_q, dvd_q[15]};
        trial     = shifted - {2'b00, dsr_q};
        no_borrow = ~trial[9];
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    prem_d  = 9'd0;
                    cnt_d   = 5'd0;
                    state_d = (divisor == 8'd0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                prem_d = no_borrow ? trial[8:0] : shifted[8:0];
                dvd_d  = {dvd_q[14:0], no_borrow};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dsr_q == 8'd0) begin
                    // dividend register was never shifted on the zero-divisor path
                    quot_d = 16'hFFFF;
                    rem_d  = dvd_q[7:0];
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = dvd_q;
                    rem_d  = prem_q[7:0];
                    dbz_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= 16'd0;
            dsr_q   <= 8'd0;
            prem_q  <= 9'd0;
            cnt_q   <= 5'd0;
            quot_q  <= 16'd0;
            rem_q   <= 8'd0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
